ball_game_ctrl: RTL

//  Game-state producer for the right-player video overlay path: owns ball position, ball size select, score,

---
 rtl/pong_pkg.sv | 42 ++++
 rtl/ball_lfsr.sv | 31 +++
 rtl/ball_game_ctrl.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/pong_pkg.sv
// ----------------------------------------------------------------------------
// pong_pkg
// Shared game constants, FSM state type and ball-size decode for the
// right-player overlay game controller (ball_game_ctrl, ball_lfsr).
// ----------------------------------------------------------------------------
package pong_pkg;

   localparam int unsigned H_RES      = 640;
   localparam int unsigned V_RES      = 480;
   localparam int unsigned SERVE_Y    = 240;
   localparam int unsigned SPEED_X    = 4;
   localparam int unsigned SPEED_Y    = 2;
   localparam int unsigned HIT_THRESH = 32;
   localparam int unsigned SCORE_MAX  = 99;

   localparam int unsigned POS_W   = 10;
   localparam int unsigned CMP_W   = 11;
   localparam int unsigned SCORE_W = 8;
   localparam int unsigned HIT_W   = 16;
   localparam int unsigned LFSR_W  = 8;

   localparam logic [LFSR_W-1:0] LFSR_SEED = 8'hA5;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SERVE = 2'd1,
      MOVE  = 2'd2,
      OVER  = 2'd3
   } state_t;

   // Ball edge length in pixels for a size select; code 3 is never produced.
   function automatic logic [POS_W-1:0] ball_size(input logic [1:0] sel);
      logic [POS_W-1:0] s;
      case (sel)
         2'd1:    s = POS_W'(40);
         2'd2:    s = POS_W'(64);
         default: s = POS_W'(20);
      endcase
      return s;
   endfunction

endpackage

// File: rtl/ball_lfsr.sv
// ----------------------------------------------------------------------------
// ball_lfsr
// Free-running 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1.
// Reset loads the non-zero seed so the sequence never locks up.
// Ports:
//   clk   in   pixel clock
//   reset in   synchronous, active-high; loads LFSR_SEED
//   out   out  [7:0] current LFSR state
// ----------------------------------------------------------------------------
module ball_lfsr
   import pong_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   output logic [LFSR_W-1:0] out
);

   logic feedback;

   // Taps at stages 8,6,5,4 of the polynomial
   assign feedback = out[7] ^ out[5] ^ out[4] ^ out[3];

   always_ff @(posedge clk) begin
      if (reset) begin
         out <= LFSR_SEED;
      end else begin
         out <= {out[LFSR_W-2:0], feedback};
      end
   end

endmodule

// File: rtl/ball_game_ctrl.sv
// ----------------------------------------------------------------------------
// ball_game_ctrl
// Game-state producer for the right-player video overlay. Owns ball position,
// ball size select, score and idle/game-over flags; integrates the
// compositor's per-pixel hit indication over a frame and applies at most one
// bounce/score/lose decision per frame_tick.
//
// Optional feature: define BALL_SPEEDUP_EN to make the horizontal step grow
// with score (SPEED_X + score/4, capped at 3*SPEED_X). Default: constant step.
//
// Ports:
//   clk        in   pixel clock
//   reset      in   synchronous, active-high
//   frame_tick in   1-cycle pulse at start of vertical blanking
//   start_btn  in   debounced start/restart level
//   hit_pixel  in   current pixel is inside ball area and player-detected
//   ball_x     out  [9:0] ball top-left x
//   ball_y     out  [9:0] ball top-left y
//   score      out  [7:0] hits this game, 0..99
//   game_over  out  high in OVER
//   is_idle    out  high in IDLE
//   rand_ball  out  [1:0] ball size select 0/1/2
// ----------------------------------------------------------------------------
module ball_game_ctrl
   import pong_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               frame_tick,
   input  logic               start_btn,
   input  logic               hit_pixel,
   output logic [POS_W-1:0]   ball_x,
   output logic [POS_W-1:0]   ball_y,
   output logic [SCORE_W-1:0] score,
   output logic               game_over,
   output logic               is_idle,
   output logic [1:0]         rand_ball
);

   state_t             state, state_n;
   logic [POS_W-1:0]   ball_x_n, ball_y_n;
   logic [SCORE_W-1:0] score_n;
   logic [1:0]         rand_ball_n;
   logic               dir_x, dir_x_n;   // 1 = moving right (+)
   logic               dir_y, dir_y_n;   // 1 = moving down (+)
   logic [HIT_W-1:0]   hit_cnt, hit_cnt_n;

   logic [LFSR_W-1:0]  lfsr;
   logic [5:0]         lfsr_unused;

   logic [CMP_W-1:0]   size_c;
   logic [CMP_W-1:0]   step_x_c;
   logic [CMP_W-1:0]   x_ext_c;
   logic [CMP_W-1:0]   y_ext_c;

   ball_lfsr u_lfsr (
      .clk   (clk),
      .reset (reset),
      .out   (lfsr)
   );

   // Only the low two bits feed the size select
   assign lfsr_unused = lfsr[7:2];

   // Per-frame geometry in 11 bits so edge compares never wrap
   always_comb begin
      size_c  = CMP_W'(ball_size(rand_ball));
      x_ext_c = {1'b0, ball_x};
      y_ext_c = {1'b0, ball_y};
`ifdef BALL_SPEEDUP_EN
      step_x_c = CMP_W'(SPEED_X) + CMP_W'(score[7:2]);
      if (step_x_c > CMP_W'(3 * SPEED_X)) begin
         step_x_c = CMP_W'(3 * SPEED_X);
      end
`else
      step_x_c = CMP_W'(SPEED_X);
`endif
   end

   // Next-state and next-datapath logic
   always_comb begin
      state_n     = state;
      ball_x_n    = ball_x;
      ball_y_n    = ball_y;
      score_n     = score;
      rand_ball_n = rand_ball;
      dir_x_n     = dir_x;
      dir_y_n     = dir_y;
      hit_cnt_n   = hit_cnt;

      case (state)
         IDLE: begin
            if (start_btn) begin
               state_n = SERVE;
            end
         end

         SERVE: begin
            rand_ball_n = (lfsr[1:0] == 2'd3) ? 2'd0 : lfsr[1:0];
            ball_x_n    = '0;
            ball_y_n    = POS_W'(SERVE_Y);
            dir_x_n     = 1'b1;
            hit_cnt_n   = '0;
            state_n     = MOVE;
         end

         MOVE: begin
            if (frame_tick) begin
               hit_cnt_n = '0;

               // Horizontal: hit beats right-edge loss beats left exit
               if (dir_x && (hit_cnt >= HIT_W'(HIT_THRESH))) begin
                  dir_x_n = 1'b0;
                  if (score < SCORE_W'(SCORE_MAX)) begin
                     score_n = score + SCORE_W'(1);
                  end
               end else if (dir_x && (x_ext_c + size_c + step_x_c >= CMP_W'(H_RES))) begin
                  ball_x_n = POS_W'(CMP_W'(H_RES) - size_c);
                  state_n  = OVER;
               end else if (!dir_x && (x_ext_c < step_x_c)) begin
                  state_n = SERVE;
               end else if (dir_x) begin
                  ball_x_n = ball_x + POS_W'(step_x_c);
               end else begin
                  ball_x_n = ball_x - POS_W'(step_x_c);
               end

               // Vertical: clamp to the wall and reflect
               if (dir_y && (y_ext_c + size_c + CMP_W'(SPEED_Y) >= CMP_W'(V_RES))) begin
                  ball_y_n = POS_W'(CMP_W'(V_RES) - size_c);
                  dir_y_n  = 1'b0;
               end else if (!dir_y && (y_ext_c < CMP_W'(SPEED_Y))) begin
                  ball_y_n = '0;
                  dir_y_n  = 1'b1;
               end else if (dir_y) begin
                  ball_y_n = ball_y + POS_W'(SPEED_Y);
               end else begin
                  ball_y_n = ball_y - POS_W'(SPEED_Y);
               end
            end else if (hit_pixel && dir_x && (hit_cnt != '1)) begin
               hit_cnt_n = hit_cnt + HIT_W'(1);
            end
         end

         OVER: begin
            if (start_btn) begin
               state_n = SERVE;
               score_n = '0;
            end
         end

         default: begin
            state_n = IDLE;
         end
      endcase
   end

   // State and datapath registers; flags track the state being entered
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         ball_x    <= '0;
         ball_y    <= POS_W'(SERVE_Y);
         score     <= '0;
         rand_ball <= 2'd0;
         dir_x     <= 1'b1;
         dir_y     <= 1'b1;
         hit_cnt   <= '0;
         game_over <= 1'b0;
         is_idle   <= 1'b1;
      end else begin
         state     <= state_n;
         ball_x    <= ball_x_n;
         ball_y    <= ball_y_n;
         score     <= score_n;
         rand_ball <= rand_ball_n;
         dir_x     <= dir_x_n;
         dir_y     <= dir_y_n;
         hit_cnt   <= hit_cnt_n;
         game_over <= (state_n == OVER);
         is_idle   <= (state_n == IDLE);
      end
   end

endmodule
